// File: rtl/dcache_responder_if.sv
// ============================================================================
// dcache_responder_if
// ----------------------------------------------------------------------------
// Groups everything that connects to the data cache responder, apart from
// clock and reset.
//   Core side:
//     addr_cache, wdata_cache, write_enable_cache, read_enable_cache,
//     vec_wdata_cache, vec_mode_cache, vec_mask_cache      (core -> cache)
//     rdata_cache, vec_rdata_cache, miss_cache             (cache -> core)
//   Memory side:
//     mem_req, mem_we, mem_addr, mem_wdata                 (cache -> memory)
//     mem_rdata, mem_ack                                   (memory -> cache)
// The cache itself uses the slave modport. Whatever drives both the core
// side and the memory side (normally the testbench) uses the master modport.
// ============================================================================
interface dcache_responder_if;

   // Core request port
   logic [31:0]  addr_cache;
   logic [31:0]  wdata_cache;
   logic [31:0]  rdata_cache;
   logic         write_enable_cache;
   logic         read_enable_cache;
   logic         miss_cache;
   logic [127:0] vec_wdata_cache;
   logic [127:0] vec_rdata_cache;
   logic         vec_mode_cache;
   logic [3:0]   vec_mask_cache;

   // Line-wide memory port
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ack;

   // The cache receives core requests and memory responses, and drives
   // read data, the stall and the memory request.
   modport slave (
      input  addr_cache, wdata_cache, write_enable_cache, read_enable_cache,
             vec_wdata_cache, vec_mode_cache, vec_mask_cache,
             mem_rdata, mem_ack,
      output rdata_cache, vec_rdata_cache, miss_cache,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   // The mirror image: issues core requests and answers memory requests.
   modport master (
      output addr_cache, wdata_cache, write_enable_cache, read_enable_cache,
             vec_wdata_cache, vec_mode_cache, vec_mask_cache,
             mem_rdata, mem_ack,
      input  rdata_cache, vec_rdata_cache, miss_cache,
             mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/dcache_responder.sv
// ============================================================================
// dcache_responder
// ----------------------------------------------------------------------------
// This is a direct-mapped, write-back, write-allocate data cache with 128-bit
// (four-word) lines. It sits between the core's cache request port and a
// line-wide req/ack memory.
//
// A hit is served in the cycle the request arrives. On a miss the cache holds
// miss_cache high. If the victim line is dirty, the cache first writes it back.
// It then refills the line. After that the request hits in the first IDLE
// cycle.
//
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   rst   - asynchronous, active-high reset
//   bus   - dcache_responder_if.slave carrying the core request port
//           (addr/wdata/rdata/enables/miss plus vec_* line access) and the
//           memory port (mem_req/we/addr/wdata/rdata/ack)
//
// Parameter:
//   INDEX_W - line index width. The cache holds 2**INDEX_W lines.
//             The tag is addr[31:INDEX_W+4].
// ============================================================================
module dcache_responder #(
   parameter int INDEX_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   dcache_responder_if.slave bus
);

   localparam int NUM_LINES = 1 << INDEX_W;
   localparam int TAG_W     = 28 - INDEX_W;

   typedef enum logic [1:0] {
      IDLE,
      WB,
      FILL
   } state_t;

   state_t state, state_next;

   // Line storage. Only valid and dirty are reset. Data and tags are
   // meaningless until the line has been filled.
   logic [127:0]         data_mem [NUM_LINES];
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;

   // Request decode
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   req_tag;
   logic [1:0]         word_sel;
   logic               req;
   logic               hit;
   logic               write_hit;
   logic [127:0]       cur_line;
   logic [127:0]       write_line;

   // Registered memory port
   logic         mem_req_q;
   logic         mem_we_q;
   logic [31:0]  mem_addr_q;
   logic [127:0] mem_wdata_q;

   // One-cycle events decoded by the FSM
   logic start_wb;
   logic start_fill;
   logic wb_done;
   logic fill_done;

   // The byte offset within a word has no meaning for a word-addressed cache.
   logic unused_byte_offset;
   assign unused_byte_offset = ^bus.addr_cache[1:0];

   assign idx      = bus.addr_cache[INDEX_W+3:4];
   assign req_tag  = bus.addr_cache[31:INDEX_W+4];
   assign word_sel = bus.addr_cache[3:2];
   assign cur_line = data_mem[idx];

   // A write that arrives together with a read is treated as a write.
   // Both are covered by req.
   assign req       = bus.read_enable_cache | bus.write_enable_cache;
   assign hit       = valid_q[idx] && (tag_mem[idx] == req_tag);
   assign write_hit = bus.write_enable_cache && hit && (state == IDLE);

   // The stall is purely combinational. A request completes only when the
   // FSM is idle and the line is present. In every other case the core
   // must hold its request.
   assign bus.miss_cache = req && !((state == IDLE) && hit);

   // Read data appears in the same cycle on a hit. With no hit, zeros are
   // returned, so stale line contents never leak onto the core bus.
   assign bus.rdata_cache     = hit ? cur_line[{word_sel, 5'd0} +: 32] : 32'd0;
   assign bus.vec_rdata_cache = hit ? cur_line : 128'd0;

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   // Build the line image that a write hit will store. A vector write
   // replaces only the words whose mask bit is set. An all-zero mask
   // therefore leaves the data untouched, but the line is still marked
   // dirty. A scalar write replaces the single selected word.
   always_comb begin
      write_line = cur_line;
      if (bus.vec_mode_cache) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.vec_mask_cache[i]) begin
               write_line[32*i +: 32] = bus.vec_wdata_cache[32*i +: 32];
            end
         end
      end else begin
         write_line[{word_sel, 5'd0} +: 32] = bus.wdata_cache;
      end
   end

   // Next-state logic for the miss handler. From IDLE, a miss goes to WB
   // when the victim line holds dirty data. Otherwise it goes straight to
   // FILL. A completed write-back flows directly into the refill, so
   // mem_req stays high across that transition. mem_ack is only acted on
   // in WB and FILL, so a stray ack while idle has no effect.
   always_comb begin
      state_next = state;
      start_wb   = 1'b0;
      start_fill = 1'b0;
      wb_done    = 1'b0;
      fill_done  = 1'b0;
      case (state)
         IDLE: begin
            if (req && !hit) begin
               if (valid_q[idx] && dirty_q[idx]) begin
                  state_next = WB;
                  start_wb   = 1'b1;
               end else begin
                  state_next = FILL;
                  start_fill = 1'b1;
               end
            end
         end
         WB: begin
            if (bus.mem_ack) begin
               state_next = FILL;
               wb_done    = 1'b1;
               start_fill = 1'b1;
            end
         end
         FILL: begin
            if (bus.mem_ack) begin
               state_next = IDLE;
               fill_done  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register, memory-port registers and line status bits.
   // The memory port is loaded when a transfer starts and then left alone
   // until the ack, so the memory sees stable values for the whole
   // transfer. Reset drops mem_req at once, invalidates every line and
   // abandons any transfer in flight. Dirty data is lost on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 128'd0;
         valid_q     <= '0;
         dirty_q     <= '0;
      end else begin
         state <= state_next;
         if (start_wb) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {tag_mem[idx], idx, 4'b0000};
            mem_wdata_q <= cur_line;
         end else if (start_fill) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {bus.addr_cache[31:4], 4'b0000};
         end else if (fill_done) begin
            mem_req_q <= 1'b0;
         end
         if (wb_done) begin
            dirty_q[idx] <= 1'b0;
         end
         if (fill_done) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end
         if (write_hit) begin
            dirty_q[idx] <= 1'b1;
         end
      end
   end

   // Line data and tag arrays. They have no reset, because the valid bits
   // say whether their contents mean anything. A refill installs the
   // returned line and its tag. A write hit stores the merged line.
   // The two cases never coincide, because a write hit requires IDLE.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_mem[idx] <= bus.mem_rdata;
         tag_mem[idx]  <= req_tag;
      end else if (write_hit) begin
         data_mem[idx] <= write_line;
      end
   end

endmodule

// File: tb/tb_dcache_responder.sv
// ============================================================================
// tb_dcache_responder
// ----------------------------------------------------------------------------
// Self-checking bench for dcache_responder.
//
// The bench plays both the core and the backing memory. The memory answers
// every request after a programmable number of cycles and keeps a log of
// what it was asked for.
//
// Expected values come from two sources:
//   - A table of hand-computed vectors.
//   - A behavioural model. The model keeps the core-visible contents of every
//     line, plus a record of which line each index should currently hold.
//     From these it predicts hits, miss duration, write-backs and read data.
// ============================================================================
module tb_dcache_responder;

   localparam int INDEX_W   = 8;
   localparam int NUM_LINES = 1 << INDEX_W;

   logic clk = 1'b0;
   logic rst;

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   dcache_responder_if bus ();

   dcache_responder #(.INDEX_W(INDEX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks    = 0;
   int errors    = 0;
   int ack_delay = 0;

   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [127:0] wdata;
   } txn_t;

   txn_t txn_log[$];

   // Backing memory contents and core-visible contents, both keyed by
   // line address.
   logic [127:0] backing [logic [27:0]];
   logic [127:0] golden  [logic [27:0]];

   // Which line each index should currently hold
   bit          res_valid [NUM_LINES];
   logic [27:0] res_la    [NUM_LINES];
   bit          res_dirty [NUM_LINES];

   typedef struct {
      string        name;
      logic         is_wr;
      logic         is_vec;
      logic [31:0]  addr;
      logic [31:0]  wdata;
      logic [127:0] vwd;
      logic [3:0]   mask;
      int           dly;
      int           exp_miss;
      bit           chk_data;
      logic [31:0]  exp_rdata;
      logic [127:0] exp_vec;
      int           exp_txns;
      bit           chk_wb;
      logic [31:0]  exp_wb_addr;
      logic [127:0] exp_wb_data;
   } vec_t;

   // Power-on memory contents: word i of line la is {C, la[23:0], i}
   function automatic logic [127:0] lineInit(input logic [27:0] la);
      return {4'hC, la[23:0], 4'h3, 4'hC, la[23:0], 4'h2,
              4'hC, la[23:0], 4'h1, 4'hC, la[23:0], 4'h0};
   endfunction

   function automatic logic [127:0] backingView(input logic [27:0] la);
      if (backing.exists(la)) return backing[la];
      return lineInit(la);
   endfunction

   function automatic logic [127:0] coreView(input logic [27:0] la);
      if (golden.exists(la)) return golden[la];
      return backingView(la);
   endfunction

   function automatic logic [127:0] mergeLine(input logic [127:0] old, input logic is_vec,
                                              input logic [1:0] w, input logic [31:0] wd,
                                              input logic [127:0] vwd, input logic [3:0] msk);
      logic [127:0] r;
      r = old;
      if (is_vec) begin
         for (int i = 0; i < 4; i++) begin
            if (msk[i]) r[32*i +: 32] = vwd[32*i +: 32];
         end
      end else begin
         r[32*w +: 32] = wd;
      end
      return r;
   endfunction

   // Predict the outcome of one access.
   // A miss costs two cycles plus the ack delay for each line transfer,
   // minus one cycle when a write-back and a refill run back to back.
   function automatic void modelPredict(input logic [31:0] a, input int dly,
                                        output int exp_miss, output int exp_txns,
                                        output logic wb, output logic [31:0] wb_addr,
                                        output logic [127:0] wb_data);
      logic [27:0]        la;
      logic [INDEX_W-1:0] ix;
      la = a[31:4];
      ix = la[INDEX_W-1:0];
      wb = 1'b0;
      wb_addr = 32'd0;
      wb_data = 128'd0;
      if (res_valid[ix] && res_la[ix] == la) begin
         exp_miss = 0;
         exp_txns = 0;
      end else if (res_valid[ix] && res_dirty[ix]) begin
         wb       = 1'b1;
         wb_addr  = {res_la[ix], 4'h0};
         wb_data  = coreView(res_la[ix]);
         exp_miss = 2 * dly + 3;
         exp_txns = 2;
      end else begin
         exp_miss = dly + 2;
         exp_txns = 1;
      end
   endfunction

   function automatic void modelCommit(input logic is_wr, input logic is_vec, input logic [31:0] a,
                                       input logic [31:0] wd, input logic [127:0] vwd,
                                       input logic [3:0] msk);
      logic [27:0]        la;
      logic [INDEX_W-1:0] ix;
      la = a[31:4];
      ix = la[INDEX_W-1:0];
      if (!(res_valid[ix] && res_la[ix] == la)) begin
         res_valid[ix] = 1'b1;
         res_la[ix]    = la;
         res_dirty[ix] = 1'b0;
      end
      if (is_wr) begin
         golden[la]    = mergeLine(coreView(la), is_vec, a[3:2], wd, vwd, msk);
         res_dirty[ix] = 1'b1;
      end
   endfunction

   // Reset empties the cache. Dirty data that was never written back is
   // lost, so the core then sees the backing memory again.
   function automatic void modelReset();
      golden.delete();
      for (int i = 0; i < NUM_LINES; i++) begin
         res_valid[i] = 1'b0;
         res_dirty[i] = 1'b0;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Present one request and hold it until miss_cache drops, sampling at
   // the falling edge. The read data is captured in the completing cycle.
   // The request is released just after the edge that commits it.
   task automatic applyStimulus(input logic is_wr, input logic is_vec, input logic [31:0] a,
                                input logic [31:0] wd, input logic [127:0] vwd,
                                input logic [3:0] msk, input int dly,
                                output int miss_cycles, output logic [31:0] rd,
                                output logic [127:0] vrd);
      ack_delay = dly;
      txn_log.delete();
      bus.addr_cache         = a;
      bus.wdata_cache        = wd;
      bus.vec_wdata_cache    = vwd;
      bus.vec_mode_cache     = is_vec;
      bus.vec_mask_cache     = msk;
      bus.write_enable_cache = is_wr;
      bus.read_enable_cache  = !is_wr;
      miss_cycles = 0;
      forever begin
         @(negedge clk);
         if (!bus.miss_cache) break;
         miss_cycles++;
         if (miss_cycles > 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL access_timeout: addr %h still stalled after %0d cycles",
                     a, miss_cycles);
            break;
         end
      end
      rd  = bus.rdata_cache;
      vrd = bus.vec_rdata_cache;
      @(posedge clk);
      #1;
      bus.write_enable_cache = 1'b0;
      bus.read_enable_cache  = 1'b0;
   endtask

   task automatic checkTxns(input string prefix, input logic [31:0] a, input int exp_txns,
                            input logic chk_wb, input logic [31:0] wb_addr,
                            input logic [127:0] wb_data);
      checkOutput({prefix, "_txn_count"}, 128'(txn_log.size()), 128'(exp_txns));
      if (txn_log.size() == exp_txns && exp_txns > 0) begin
         if (chk_wb) begin
            checkOutput({prefix, "_wb_we"},   128'(txn_log[0].we),   128'(1));
            checkOutput({prefix, "_wb_addr"}, 128'(txn_log[0].addr), 128'(wb_addr));
            checkOutput({prefix, "_wb_data"}, txn_log[0].wdata,      wb_data);
         end
         checkOutput({prefix, "_fill_we"},   128'(txn_log[exp_txns-1].we),   128'(0));
         checkOutput({prefix, "_fill_addr"}, 128'(txn_log[exp_txns-1].addr),
                     128'({a[31:4], 4'h0}));
      end
   endtask

   // One access checked entirely against the behavioural model
   task automatic modelAccess(input string name, input logic is_wr, input logic is_vec,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [127:0] vwd, input logic [3:0] msk, input int dly,
                              output logic [31:0] rd);
      int           em, et, mc;
      logic         wb;
      logic [31:0]  wba;
      logic [127:0] wbd, exp_line, vrd;
      modelPredict(a, dly, em, et, wb, wba, wbd);
      exp_line = coreView(a[31:4]);
      applyStimulus(is_wr, is_vec, a, wd, vwd, msk, dly, mc, rd, vrd);
      checkOutput({name, "_miss_cycles"}, 128'(mc), 128'(em));
      checkTxns(name, a, et, wb, wba, wbd);
      if (!is_wr) begin
         checkOutput({name, "_rdata"}, 128'(rd), 128'(exp_line[32*a[3:2] +: 32]));
         checkOutput({name, "_vec_rdata"}, vrd, exp_line);
      end
      modelCommit(is_wr, is_vec, a, wd, vwd, msk);
   endtask

   // Backing memory. Each request is logged when it first appears. The ack
   // comes ack_delay cycles later, so a delay of 0 acks in the same cycle
   // that mem_req rises. While the memory waits, it also checks that the
   // request stays unchanged.
   initial begin
      txn_t cur;
      bit   busy;
      int   waited;
      busy = 1'b0;
      waited = 0;
      cur = '{we: 1'b0, addr: 32'd0, wdata: 128'd0};
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 128'd0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ack = 1'b0;
         if (rst || !bus.mem_req) begin
            busy = 1'b0;
         end else begin
            if (!busy) begin
               busy      = 1'b1;
               waited    = 0;
               cur.we    = bus.mem_we;
               cur.addr  = bus.mem_addr;
               cur.wdata = bus.mem_wdata;
               txn_log.push_back(cur);
            end else begin
               checkOutput("mem_stable_we",   128'(bus.mem_we),   128'(cur.we));
               checkOutput("mem_stable_addr", 128'(bus.mem_addr), 128'(cur.addr));
               if (cur.we) checkOutput("mem_stable_wdata", bus.mem_wdata, cur.wdata);
            end
            if (waited >= ack_delay) begin
               bus.mem_ack = 1'b1;
               if (cur.we) backing[cur.addr[31:4]] = cur.wdata;
               else        bus.mem_rdata = backingView(cur.addr[31:4]);
               busy = 1'b0;
            end else begin
               waited++;
            end
         end
      end
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t         vecs [9];
      int           mc;
      logic [31:0]  rd;
      logic [127:0] vrd;

      // Hand-computed sequence on index 0 (0x1000/0x2000 share it)
      vecs[0] = '{"cold_read", 0, 0, 32'h0000_1004, 32'd0, 128'd0, 4'h0, 3,
                  5, 1, 32'hC000_1001, {32'hC000_1003, 32'hC000_1002, 32'hC000_1001, 32'hC000_1000},
                  1, 0, 32'd0, 128'd0};
      vecs[1] = '{"scalar_write_hit", 1, 0, 32'h0000_1008, 32'hDEAD_BEEF, 128'd0, 4'h0, 0,
                  0, 0, 32'd0, 128'd0, 0, 0, 32'd0, 128'd0};
      vecs[2] = '{"read_after_write", 0, 0, 32'h0000_1008, 32'd0, 128'd0, 4'h0, 0,
                  0, 1, 32'hDEAD_BEEF, {32'hC000_1003, 32'hDEAD_BEEF, 32'hC000_1001, 32'hC000_1000},
                  0, 0, 32'd0, 128'd0};
      vecs[3] = '{"dirty_evict", 0, 0, 32'h0000_2000, 32'd0, 128'd0, 4'h0, 2,
                  7, 1, 32'hC000_2000, {32'hC000_2003, 32'hC000_2002, 32'hC000_2001, 32'hC000_2000},
                  2, 1, 32'h0000_1000,
                  {32'hC000_1003, 32'hDEAD_BEEF, 32'hC000_1001, 32'hC000_1000}};
      vecs[4] = '{"vec_write_mask0101", 1, 1, 32'h0000_2000, 32'd0,
                  {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 4'b0101, 0,
                  0, 0, 32'd0, 128'd0, 0, 0, 32'd0, 128'd0};
      vecs[5] = '{"vec_read_merged", 0, 1, 32'h0000_2000, 32'd0, 128'd0, 4'h0, 0,
                  0, 1, 32'h1111_1111, {32'hC000_2003, 32'h3333_3333, 32'hC000_2001, 32'h1111_1111},
                  0, 0, 32'd0, 128'd0};
      vecs[6] = '{"evict_ack_same_cycle", 0, 0, 32'h0000_1004, 32'd0, 128'd0, 4'h0, 0,
                  3, 1, 32'hC000_1001, {32'hC000_1003, 32'hDEAD_BEEF, 32'hC000_1001, 32'hC000_1000},
                  2, 1, 32'h0000_2000,
                  {32'hC000_2003, 32'h3333_3333, 32'hC000_2001, 32'h1111_1111}};
      vecs[7] = '{"vec_write_mask0000", 1, 1, 32'h0000_1000, 32'd0, {4{32'hFFFF_FFFF}}, 4'b0000, 0,
                  0, 0, 32'd0, 128'd0, 0, 0, 32'd0, 128'd0};
      vecs[8] = '{"evict_after_mask0000", 0, 0, 32'h0000_200C, 32'd0, 128'd0, 4'h0, 1,
                  5, 1, 32'hC000_2003, {32'hC000_2003, 32'h3333_3333, 32'hC000_2001, 32'h1111_1111},
                  2, 1, 32'h0000_1000,
                  {32'hC000_1003, 32'hDEAD_BEEF, 32'hC000_1001, 32'hC000_1000}};

      // Reset state
      rst                    = 1'b1;
      bus.addr_cache         = 32'd0;
      bus.wdata_cache        = 32'd0;
      bus.vec_wdata_cache    = 128'd0;
      bus.vec_mode_cache     = 1'b0;
      bus.vec_mask_cache     = 4'h0;
      bus.write_enable_cache = 1'b0;
      bus.read_enable_cache  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_miss",      128'(bus.miss_cache),      128'(0));
      checkOutput("reset_rdata",     128'(bus.rdata_cache),     128'(0));
      checkOutput("reset_vec_rdata", bus.vec_rdata_cache,       128'(0));
      checkOutput("reset_mem_req",   128'(bus.mem_req),         128'(0));
      checkOutput("reset_mem_we",    128'(bus.mem_we),          128'(0));
      checkOutput("reset_mem_addr",  128'(bus.mem_addr),        128'(0));
      checkOutput("reset_mem_wdata", bus.mem_wdata,             128'(0));
      bus.read_enable_cache = 1'b1;
      bus.addr_cache        = 32'h0000_1004;
      #1;
      checkOutput("reset_req_forces_miss", 128'(bus.miss_cache), 128'(1));
      checkOutput("nohit_rdata_zero",      128'(bus.rdata_cache), 128'(0));
      bus.read_enable_cache = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Table-driven directed vectors
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].is_wr, vecs[i].is_vec, vecs[i].addr, vecs[i].wdata, vecs[i].vwd,
                       vecs[i].mask, vecs[i].dly, mc, rd, vrd);
         checkOutput({vecs[i].name, "_miss_cycles"}, 128'(mc), 128'(vecs[i].exp_miss));
         checkTxns(vecs[i].name, vecs[i].addr, vecs[i].exp_txns, vecs[i].chk_wb,
                   vecs[i].exp_wb_addr, vecs[i].exp_wb_data);
         if (vecs[i].chk_data) begin
            checkOutput({vecs[i].name, "_rdata"},     128'(rd), 128'(vecs[i].exp_rdata));
            checkOutput({vecs[i].name, "_vec_rdata"}, vrd,      vecs[i].exp_vec);
         end
         modelCommit(vecs[i].is_wr, vecs[i].is_vec, vecs[i].addr, vecs[i].wdata, vecs[i].vwd,
                     vecs[i].mask);
      end

      // Randomized traffic over three tags and three indexes, which forces
      // frequent conflicts and write-backs
      for (int n = 0; n < 150; n++) begin
         logic [31:0]  a;
         logic [127:0] vwd;
         a = (32'($urandom_range(1, 3)) << 12) | (32'($urandom_range(0, 2)) << 4) |
             (32'($urandom_range(0, 3)) << 2);
         vwd = {$urandom, $urandom, $urandom, $urandom};
         modelAccess($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     a, $urandom, vwd, 4'($urandom_range(0, 15)), $urandom_range(0, 3), rd);
      end

      // Long ack hold-off. The memory checks stability every waiting cycle,
      // and miss must stay high for the whole transfer.
      modelAccess("ack_holdoff", 1'b0, 1'b0, 32'h0000_7000, 32'd0, 128'd0, 4'h0, 50, rd);

      // Leave a dirty line that will never be written back
      modelAccess("dirty_before_rst", 1'b1, 1'b0, 32'h0000_5020, 32'h1234_5678, 128'd0, 4'h0,
                  1, rd);

      // Reset in the middle of a refill
      ack_delay = 20;
      txn_log.delete();
      bus.addr_cache        = 32'h0000_6030;
      bus.vec_mode_cache    = 1'b0;
      bus.read_enable_cache = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("rst_mid_fill_req_before",  128'(bus.mem_req),    128'(1));
      checkOutput("rst_mid_fill_miss_before", 128'(bus.miss_cache), 128'(1));
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_fill_req_async", 128'(bus.mem_req),    128'(0));
      checkOutput("rst_mid_fill_miss",      128'(bus.miss_cache), 128'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.read_enable_cache = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      modelAccess("rst_reread", 1'b0, 1'b0, 32'h0000_6030, 32'd0, 128'd0, 4'h0, 1, rd);
      modelAccess("rst_dirty_lost", 1'b0, 1'b0, 32'h0000_5020, 32'd0, 128'd0, 4'h0, 1, rd);
      checkOutput("rst_dirty_lost_const", 128'(rd), 128'(32'hC000_5020));

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
